wave_capture_multi: RTL and testbench

Parametrised successor to the synthesizer wave-capture stage. Watches the synthesizer's sample stream and, on a selectable trigger, writes one decimated, offset-binary frame into the back half of a double-buffered dual-port RAM. Hands the frame to the wave display through a read_index ping-pong. Adds over the previous generation:
- runtime trigger modes
- sample decimation
- auto-trigger timeout
- abort on note change

---
 rtl/wave_capture_pkg.sv | 23 ++
 rtl/wave_trigger.sv | 84 ++++++++
 rtl/wave_capture_multi.sv | 165 ++++++++++++++++
 tb/tb_wave_capture_multi.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_pkg.sv
// Shared types and helpers for the multi-mode wave capture stage.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_e;

    localparam logic [1:0] TRIG_FREE    = 2'd0;
    localparam logic [1:0] TRIG_RISING  = 2'd1;
    localparam logic [1:0] TRIG_FALLING = 2'd2;
    localparam logic [1:0] TRIG_SLOPE   = 2'd3;

    // Two's complement MSB slice to offset binary: flip the top bit of the slice.
    function automatic logic [63:0] to_offset_binary(input logic [63:0] msbs,
                                                      input int unsigned width);
        logic [63:0] flip;
        flip = 64'd1 << (width - 32'd1);
        return msbs ^ flip;
    endfunction

endpackage

// File: rtl/wave_trigger.sv
// Trigger generation: crossing detect, slope-matched target and ARMED timeout.
module wave_trigger
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int TOL          = 20,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    strobe_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic [1:0]              mode_i,
    input  logic                    armed_i,
    input  logic                    notes_changed_i,
    output logic                    trig_o,
    output logic                    forced_o
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic [SAMPLE_WIDTH-1:0] target_q, target_d;
    logic                    target_valid_q, target_valid_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [SAMPLE_WIDTH-1:0] diff_s, lo_s, hi_s;
    logic                    rising_s, falling_s, cond_s, timeout_hit_s;

    always_comb begin
        rising_s      = prev_q[SAMPLE_WIDTH-1] & ~sample_i[SAMPLE_WIDTH-1];
        falling_s     = ~prev_q[SAMPLE_WIDTH-1] & sample_i[SAMPLE_WIDTH-1];
        diff_s        = sample_i - prev_q;
        lo_s          = target_q - SAMPLE_WIDTH'(TOL);
        hi_s          = target_q + SAMPLE_WIDTH'(TOL);
        timeout_hit_s = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));

        case (mode_i)
            TRIG_FREE:    cond_s = 1'b1;
            TRIG_RISING:  cond_s = rising_s;
            TRIG_FALLING: cond_s = falling_s;
            TRIG_SLOPE:   cond_s = rising_s && target_valid_q && (diff_s > lo_s) && (diff_s < hi_s);
            default:      cond_s = 1'b0;
        endcase

        trig_o   = strobe_i && armed_i && (cond_s || timeout_hit_s);
        forced_o = !cond_s && timeout_hit_s;

        prev_d         = strobe_i ? sample_i : prev_q;
        target_d       = target_q;
        target_valid_d = target_valid_q;
        if (notes_changed_i) begin
            target_valid_d = 1'b0;
        end else if (strobe_i && (mode_i == TRIG_SLOPE) && rising_s && !target_valid_q) begin
            // The latching crossing only learns the slope; it never fires.
            target_d       = diff_s;
            target_valid_d = 1'b1;
        end else begin
            target_valid_d = target_valid_q;
        end

        if (!armed_i || notes_changed_i) begin
            to_cnt_d = '0;
        end else if (strobe_i) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q         <= '0;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            prev_q         <= prev_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

endmodule

// File: rtl/wave_capture_multi.sv
// Captures one decimated offset-binary frame per trigger into the half of a
// ping-pong RAM that the display is not reading.
module wave_capture_multi
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int OUT_WIDTH    = 8,
    parameter int DEPTH        = 640,
    parameter int ADDR_WIDTH   = 10,
    parameter int NOTES_WIDTH  = 56,
    parameter int TOL          = 20,
    parameter int DECIM_WIDTH  = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    input  logic [NOTES_WIDTH-1:0]  to_display,
    input  logic [1:0]              trig_mode,
    input  logic [DECIM_WIDTH-1:0]  decim,
    output logic [ADDR_WIDTH:0]     write_address,
    output logic                    write_enable,
    output logic [OUT_WIDTH-1:0]    write_sample,
    output logic                    read_index,
    output logic                    trig_forced,
    output logic                    busy
);

    state_e                 state_q, state_d;
    logic                   read_index_q, read_index_d;
    logic [ADDR_WIDTH-1:0]  count_q, count_d;
    logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH:0]    wa_q, wa_d;
    logic [OUT_WIDTH-1:0]   ws_q, ws_d;
    logic                   forced_q, forced_d;
    logic [NOTES_WIDTH-1:0] notes_q;
    logic                   notes_changed_s, trig_s, trig_forced_s;
    logic [63:0]            ob_s;

    assign notes_changed_s = (to_display != notes_q);

    wave_trigger #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .TOL          (TOL),
        .TIMEOUT      (TIMEOUT)
    ) u_trigger (
        .clk             (clk),
        .reset           (reset),
        .strobe_i        (new_sample_ready),
        .sample_i        (new_sample_in),
        .mode_i          (trig_mode),
        .armed_i         (state_q == ARMED),
        .notes_changed_i (notes_changed_s),
        .trig_o          (trig_s),
        .forced_o        (trig_forced_s)
    );

    always_comb begin
        ob_s = to_offset_binary(64'(new_sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH]), OUT_WIDTH);

        state_d      = state_q;
        read_index_d = read_index_q;
        count_d      = count_q;
        dcnt_d       = dcnt_q;
        decim_d      = decim_q;
        we_d         = 1'b0;
        wa_d         = wa_q;
        ws_d         = ws_q;
        forced_d     = forced_q;

        // A note change discards the partial frame and beats any trigger or completion.
        if (notes_changed_s) begin
            if (state_q == ACTIVE) begin
                state_d = ARMED;
            end else begin
                state_d = state_q;
            end
            count_d = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (trig_s) begin
                        state_d  = ACTIVE;
                        forced_d = trig_forced_s;
                        decim_d  = decim;
                        dcnt_d   = '0;
                        count_d  = '0;
                    end else begin
                        state_d = ARMED;
                    end
                end
                ACTIVE: begin
                    if (new_sample_ready) begin
                        if (dcnt_q == '0) begin
                            we_d = 1'b1;
                            wa_d = {~read_index_q, count_q};
                            ws_d = ob_s[OUT_WIDTH-1:0];
                            if (count_q == ADDR_WIDTH'(DEPTH - 1)) begin
                                state_d = WAIT;
                                count_d = '0;
                            end else begin
                                count_d = count_q + ADDR_WIDTH'(1);
                            end
                        end else begin
                            count_d = count_q;
                        end
                        dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_WIDTH'(1);
                    end else begin
                        dcnt_d = dcnt_q;
                    end
                end
                WAIT: begin
                    if (wave_display_idle) begin
                        read_index_d = ~read_index_q;
                        state_d      = ARMED;
                    end else begin
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARMED;
            read_index_q <= 1'b0;
            count_q      <= '0;
            dcnt_q       <= '0;
            decim_q      <= '0;
            we_q         <= 1'b0;
            wa_q         <= '0;
            ws_q         <= '0;
            forced_q     <= 1'b0;
            notes_q      <= '0;
        end else begin
            state_q      <= state_d;
            read_index_q <= read_index_d;
            count_q      <= count_d;
            dcnt_q       <= dcnt_d;
            decim_q      <= decim_d;
            we_q         <= we_d;
            wa_q         <= wa_d;
            ws_q         <= ws_d;
            forced_q     <= forced_d;
            notes_q      <= to_display;
        end
    end

    assign write_address = wa_q;
    assign write_enable  = we_q;
    assign write_sample  = ws_q;
    assign read_index    = read_index_q;
    assign trig_forced   = forced_q;
    assign busy          = (state_q != ARMED);

endmodule

// File: tb/tb_wave_capture_multi.sv
// Scoreboard bench: stimulus queues expected RAM writes, a monitor checks them.
`timescale 1ns/1ps
module tb_wave_capture_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [55:0] to_display;
    logic [1:0]  trig_mode;
    logic [3:0]  decim;
    logic [10:0] write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        trig_forced;
    logic        busy;

    int vectors = 0;
    int errors  = 0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    wave_capture_multi #(.DEPTH(640), .TIMEOUT(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .to_display        (to_display),
        .trig_mode         (trig_mode),
        .decim             (decim),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .trig_forced       (trig_forced),
        .busy              (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected write addr %0d data %0h, none expected", write_address, write_sample);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({write_address, write_sample} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             write_address, write_sample, e[18:8], e[7:0]);
                end
            end
        end
    end

    task automatic strobe(input logic [15:0] s, input bit exp_w, input logic [10:0] addr);
        logic [7:0] ob;
        @(negedge clk);
        ob = s[15:8] ^ 8'h80;
        if (exp_w) exp_q.push_back({addr, ob});
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        @(negedge clk);
        new_sample_ready = 1'b0;
    endtask

    task automatic idle_pulse();
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = 16'h0000;
        wave_display_idle = 1'b0; to_display = 56'h0; trig_mode = 2'd1; decim = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_addr", {21'd0, write_address}, 32'd0);
        chk("rst_sample", {24'd0, write_sample}, 32'd0);
        chk("rst_ri", {31'd0, read_index}, 32'd0);
        chk("rst_forced", {31'd0, trig_forced}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Mode 1: rising crossing (negative -> non-negative) starts a frame.
        strobe(16'hF000, 1'b0, 11'd0);
        chk("m1_no_trig_on_fall", {31'd0, busy}, 32'd0);
        strobe(16'h0100, 1'b0, 11'd0);
        chk("m1_busy_after_trig", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 640; i++) begin
            s = 16'(i * 97 + 4660);
            strobe(s, 1'b1, 11'(1024 + i));
        end
        chk("m1_ri", {31'd0, read_index}, 32'd0);
        chk("m1_wait_busy", {31'd0, busy}, 32'd1);
        chk("m1_forced", {31'd0, trig_forced}, 32'd0);
        strobe(16'h0100, 1'b0, 11'd0);
        strobe(16'h8100, 1'b0, 11'd0);

        idle_pulse();
        chk("idle_ri_toggle", {31'd0, read_index}, 32'd1);
        chk("idle_armed", {31'd0, busy}, 32'd0);

        // Mode 2, decim 3: store every 4th strobe into the lower half.
        trig_mode = 2'd2; decim = 4'd3;
        strobe(16'h0100, 1'b0, 11'd0);
        strobe(16'hFF00, 1'b0, 11'd0);
        chk("m2_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 2560; i++) begin
            if (i == 1000) decim = 4'd0;
            s = 16'(i * 131 + 77);
            strobe(s, (i % 4) == 0, 11'(i / 4));
        end
        chk("m2_wait_busy", {31'd0, busy}, 32'd1);
        idle_pulse();
        chk("m2_ri_back", {31'd0, read_index}, 32'd0);

        // Mode 3: first crossing latches diff 500; window is 481..519.
        trig_mode = 2'd3; decim = 4'd0;
        strobe(16'hFF00, 1'b0, 11'd0);
        strobe(16'h00F4, 1'b0, 11'd0);
        chk("m3_latch_no_trig", {31'd0, busy}, 32'd0);
        strobe(16'hFFCE, 1'b0, 11'd0);
        strobe(16'h0032, 1'b0, 11'd0);
        chk("m3_diff100", {31'd0, busy}, 32'd0);
        strobe(16'hFF00, 1'b0, 11'd0);
        strobe(16'h0108, 1'b0, 11'd0);
        chk("m3_diff520", {31'd0, busy}, 32'd0);
        strobe(16'hFF00, 1'b0, 11'd0);
        strobe(16'h00E0, 1'b0, 11'd0);
        chk("m3_diff480", {31'd0, busy}, 32'd0);
        strobe(16'hFF00, 1'b0, 11'd0);
        strobe(16'h0107, 1'b0, 11'd0);
        chk("m3_diff519_trig", {31'd0, busy}, 32'd1);
        chk("m3_forced", {31'd0, trig_forced}, 32'd0);
        for (int i = 0; i < 640; i++) begin
            s = 16'(i * 53 + 9000);
            strobe(s, 1'b1, 11'(1024 + i));
        end
        strobe(16'h0400, 1'b0, 11'd0);
        idle_pulse();
        chk("m3_ri", {31'd0, read_index}, 32'd1);

        // DC input: the 16th ARMED strobe forces the trigger.
        trig_mode = 2'd1;
        for (int i = 0; i < 15; i++) strobe(16'h0400, 1'b0, 11'd0);
        chk("to_not_yet", {31'd0, busy}, 32'd0);
        strobe(16'h0400, 1'b0, 11'd0);
        chk("to_busy", {31'd0, busy}, 32'd1);
        chk("to_forced", {31'd0, trig_forced}, 32'd1);
        for (int i = 0; i < 640; i++) strobe(16'h0400, 1'b1, 11'(i));
        idle_pulse();
        chk("to_ri", {31'd0, read_index}, 32'd0);

        // Free-run frame aborted by a note change after 300 writes.
        trig_mode = 2'd0;
        strobe(16'h1234, 1'b0, 11'd0);
        chk("nc_busy", {31'd0, busy}, 32'd1);
        chk("nc_forced_clear", {31'd0, trig_forced}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            s = 16'(i * 211 + 3);
            strobe(s, 1'b1, 11'(1024 + i));
        end
        to_display = 56'h00_0000_0000_0042;
        @(negedge clk);
        chk("nc_armed", {31'd0, busy}, 32'd0);
        chk("nc_we", {31'd0, write_enable}, 32'd0);
        chk("nc_ri", {31'd0, read_index}, 32'd0);
        strobe(16'h2000, 1'b0, 11'd0);
        for (int i = 0; i < 5; i++) begin
            s = 16'(i * 1000 + 16'h8000);
            strobe(s, 1'b1, 11'(1024 + i));
        end

        // Reset mid-frame clears every output on the next cycle.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_we", {31'd0, write_enable}, 32'd0);
        chk("mr_addr", {21'd0, write_address}, 32'd0);
        chk("mr_sample", {24'd0, write_sample}, 32'd0);
        chk("mr_ri", {31'd0, read_index}, 32'd0);
        chk("mr_forced", {31'd0, trig_forced}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
